// File: rtl/arb_pkg.sv
// Shared types and sizes for the request arbiter in front of the 8-to-3 one-hot encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic {IDLE, GRANT} arb_state_t;

    typedef logic [N_REQ-1:0] req_vec_t;

endpackage

// File: rtl/onehot_rr_pick.sv
// Round-robin picker: first eligible bit searching downward from ptr, wrapping N_REQ-1 after 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the pick.
//
// Ports:
//   eligible  candidate request bits
//   ptr       index searched first
//   pick      one-hot winner (all-zero when nothing is eligible)
//   idx       index of the winner (don't-care when any=0)
//   any       at least one eligible bit
module onehot_rr_pick #(
    parameter int N_REQ = 8,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] hit;

    always_comb begin
        rot  = '0;
        hit  = '0;
        any  = 1'b0;
        pick = '0;
        // Rotate so the bit at ptr lands on the MSB; the search order
        // ptr, ptr-1, ... then becomes a plain highest-bit-first scan.
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = eligible[IDX_W'((i + int'(ptr) + 1) % N_REQ)];
        end
        // Ascending scan: the last hit is the highest set bit.
        for (int i = 0; i < N_REQ; i++) begin
            if (rot[i]) begin
                hit = IDX_W'(i);
                any = 1'b1;
            end
        end
        // Rotate the index back into the original bit numbering.
        idx = IDX_W'((int'(hit) + int'(ptr) + 1) % N_REQ);
        if (any) begin
            pick[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/req_onehot_arbiter.sv
// Edge-captured request arbiter driving a registered one-hot grant into the 8-to-3 encoder.
// Latency: req rise at edge k -> pending at k+1 -> grant valid at k+2; >=1 idle cycle after each ack.
// Backpressure: grant is held stable until gnt_ack_i or clr_i; new rises keep accumulating as pending.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   req_i         raw request lines, a 0->1 transition sets the pending bit
//   mask_i        1 = line not eligible for selection (pending still accumulates)
//   clr_i         drop all pending bits and abort any outstanding grant
//   gnt_ack_i     consumer accepts the current grant (ignored while idle)
//   gnt_o         registered one-hot grant, zero when not valid
//   gnt_valid_o   grant present
//   pend_o        pending register
//
// Build option ARB_FIXED_PRIO_EN: pointer frozen at N_REQ-1, i.e. strict
// highest-index-first priority, matching the encoder's code-0 ordering.
module req_onehot_arbiter
    import arb_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  req_vec_t req_i,
    input  req_vec_t mask_i,
    input  logic     clr_i,
    input  logic     gnt_ack_i,
    output req_vec_t gnt_o,
    output logic     gnt_valid_o,
    output req_vec_t pend_o
);

    arb_state_t       state, state_n;
    req_vec_t         req_prev;
    req_vec_t         pend, pend_n;
    req_vec_t         gnt, gnt_n;
    logic             gnt_valid, valid_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [IDX_W-1:0] gnt_idx, idx_n;

    req_vec_t         rise;
    req_vec_t         eligible;
    req_vec_t         pick;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    assign rise     = req_i & ~req_prev;
    assign eligible = pend & ~mask_i;

    onehot_rr_pick #(
        .N_REQ(N_REQ),
        .IDX_W(IDX_W)
    ) u_pick (
        .eligible(eligible),
        .ptr     (ptr),
        .pick    (pick),
        .idx     (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        valid_n = gnt_valid;
        ptr_n   = ptr;
        idx_n   = gnt_idx;
        pend_n  = pend;

        case (state)
            IDLE: begin
                if (!clr_i && pick_any) begin
                    gnt_n   = pick;
                    valid_n = 1'b1;
                    idx_n   = pick_idx;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                // clr_i aborts the grant and wins over a same-cycle ack;
                // the pointer only moves on a real acceptance.
                if (clr_i) begin
                    gnt_n   = '0;
                    valid_n = 1'b0;
                    state_n = IDLE;
                end else if (gnt_ack_i) begin
                    gnt_n           = '0;
                    valid_n         = 1'b0;
                    pend_n[gnt_idx] = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
                    ptr_n = (gnt_idx == '0) ? IDX_W'(N_REQ - 1) : gnt_idx - 1'b1;
`endif
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Applied after the ack clear so a rise on the granted line in the
        // ack cycle survives; clr_i is applied last so it discards rises.
        pend_n = pend_n | rise;
        if (clr_i) begin
            pend_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_prev  <= '0;
            pend      <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= IDX_W'(N_REQ - 1);
            gnt_idx   <= '0;
        end else begin
            state     <= state_n;
            req_prev  <= req_i;
            pend      <= pend_n;
            gnt       <= gnt_n;
            gnt_valid <= valid_n;
            ptr       <= ptr_n;
            gnt_idx   <= idx_n;
        end
    end

    assign gnt_o       = gnt;
    assign gnt_valid_o = gnt_valid;
    assign pend_o      = pend;

endmodule
